// File: rtl/aes_round_ctrl.sv
// AES round sequencer: issues one-hot SB/SR/MC/ARK step enables with round-key index; busy/done handshake.
// Optional macro AES_CTRL_DECRYPT_EN compiles in the inverse-cipher sequence and the inv output.
module aes_round_ctrl #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              decrypt,
  input  logic              step_done,
  output logic [3:0]        step_en,
  output logic              inv,
  output logic [KIDX_W-1:0] key_idx,
  output logic              busy,
  output logic              done
);

  localparam int RW = $clog2(NR + 1);
  localparam int SW = $clog2(4 * NR + 1);
  localparam logic [RW-1:0] RND_LAST  = RW'(NR);
  localparam logic [SW-1:0] STEP_LAST = SW'(4 * NR - 1);
  localparam logic [3:0] EN_SB  = 4'b0001;
  localparam logic [3:0] EN_SR  = 4'b0010;
  localparam logic [3:0] EN_MC  = 4'b0100;
  localparam logic [3:0] EN_ARK = 4'b1000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [1:0]    ph_q, ph_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          dec_q, dec_d;
  logic [3:0]    step_sel;
  logic [RW-1:0] rnd_key;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
    end
  end

  // rnd_q counts round groups in issue order; decrypt walks the key schedule backwards.
  assign rnd_key = dec_q ? (RND_LAST - rnd_q) : rnd_q;

  always_comb begin
    step_sel = EN_ARK;
    if (rnd_q == '0) begin
      step_sel = EN_ARK;
    end else if (rnd_q == RND_LAST) begin
      case (ph_q)
        2'd0:    step_sel = dec_q ? EN_SR : EN_SB;
        2'd1:    step_sel = dec_q ? EN_SB : EN_SR;
        default: step_sel = EN_ARK;
      endcase
    end else begin
      case (ph_q)
        2'd0:    step_sel = dec_q ? EN_SR  : EN_SB;
        2'd1:    step_sel = dec_q ? EN_SB  : EN_SR;
        2'd2:    step_sel = dec_q ? EN_ARK : EN_MC;
        default: step_sel = dec_q ? EN_MC  : EN_ARK;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    step_en = 4'b0000;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          rnd_d   = '0;
          ph_d    = '0;
          cnt_d   = '0;
`ifdef AES_CTRL_DECRYPT_EN
          dec_d   = decrypt;
`else
          dec_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        step_en = step_sel;
        state_d = WAIT;
      end
      WAIT: begin
        if (step_done) begin
          if (cnt_q == STEP_LAST) begin
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
            cnt_d   = cnt_q + 1'b1;
            if (rnd_q == '0 || ph_q == 2'd3) begin
              rnd_d = rnd_q + 1'b1;
              ph_d  = '0;
            end else begin
              ph_d  = ph_q + 1'b1;
            end
          end
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == ISSUE) || (state_q == WAIT);
  assign key_idx = busy ? KIDX_W'(rnd_key) : '0;

`ifdef AES_CTRL_DECRYPT_EN
  assign inv = busy & dec_q;
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
  assign inv = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: random step_done delays and modes against a sequence-list model.
module tb_aes_round_ctrl;
  localparam int NR     = 10;
  localparam int KIDX_W = 4;
  localparam int NSTEP  = 4 * NR;
  localparam logic [3:0] SB = 4'b0001, SR = 4'b0010, MC = 4'b0100, ARK = 4'b1000;
`ifdef AES_CTRL_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, decrypt, step_done;
  logic [3:0] step_en;
  logic inv, busy, done;
  logic [KIDX_W-1:0] key_idx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_en [NSTEP];
  int         exp_k  [NSTEP];
  int         n_seq;

  aes_round_ctrl #(.NR(NR), .KIDX_W(KIDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .step_done(step_done),
    .step_en(step_en), .inv(inv), .key_idx(key_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_step(input logic [3:0] en, input int k);
    exp_en[n_seq] = en;
    exp_k[n_seq]  = k;
    n_seq++;
  endtask

  // Reference step list written straight from the cipher round structure.
  task automatic build_seq(input bit dec);
    n_seq = 0;
    if (!dec) begin
      add_step(ARK, 0);
      for (int r = 1; r < NR; r++) begin
        add_step(SB, r); add_step(SR, r); add_step(MC, r); add_step(ARK, r);
      end
      add_step(SB, NR); add_step(SR, NR); add_step(ARK, NR);
    end else begin
      add_step(ARK, NR);
      for (int r = NR - 1; r >= 1; r--) begin
        add_step(SR, r); add_step(SB, r); add_step(ARK, r); add_step(MC, r);
      end
      add_step(SR, 0); add_step(SB, 0); add_step(ARK, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_en"}, step_en, 0);
    check_val({tag, "_key"}, key_idx, 0);
    check_val({tag, "_inv"}, inv, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input bit dec, input int mc_delay, input int rand_max,
                        input bit disturb, input int abort_at);
    bit edec;
    int cyc;
    int extra;
    int d;
    edec  = DEC_EN && dec;
    extra = 0;
    build_seq(edec);
    start   = 1'b1;
    decrypt = dec;
    cyc     = 1;
    @(negedge clk); cyc++;
    start = 1'b0;
    for (int i = 0; i < NSTEP; i++) begin
      decrypt = 1'($urandom);
      check_val("issue_en", step_en, exp_en[i]);
      check_val("issue_key", key_idx, exp_k[i]);
      check_val("issue_inv", inv, edec);
      check_val("issue_busy", busy, 1);
      check_val("issue_done", done, 0);
      if (disturb && i == 5) begin
        start     = 1'b1;
        step_done = 1'b1;
      end
      @(negedge clk); cyc++;
      start     = 1'b0;
      step_done = 1'b0;
      check_val("wait_en", step_en, 0);
      check_val("wait_key", key_idx, exp_k[i]);
      check_val("wait_done", done, 0);
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        check_idle("rst_async");
        @(negedge clk);
        check_idle("rst_hold");
        rst = 1'b1;
        return;
      end
      d = (exp_en[i] == MC && mc_delay > 0) ? mc_delay : int'($urandom_range(rand_max, 0));
      extra += d;
      repeat (d) begin
        @(negedge clk); cyc++;
        check_val("hold_en", step_en, 0);
        check_val("hold_key", key_idx, exp_k[i]);
        check_val("hold_busy", busy, 1);
      end
      step_done = 1'b1;
      @(negedge clk); cyc++;
      step_done = 1'b0;
    end
    // Latency counted with the start cycle as cycle 1.
    check_val("fin_done", done, 1);
    check_val("fin_busy", busy, 0);
    check_val("fin_en", step_en, 0);
    check_val("latency", cyc, 2 * NSTEP + 2 + extra);
    step_done = 1'b1;
    @(negedge clk);
    check_idle("post");
    @(negedge clk);
    step_done = 1'b0;
    check_idle("idle_spurious");
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    decrypt   = 1'b0;
    step_done = 1'b0;
    #1;
    check_idle("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("after_reset");

    run_op(1'b0, 0, 0, 1'b0, -1);
    run_op(1'b1, 0, 0, 1'b0, -1);
    run_op(1'($urandom), 0, 1, 1'b1, -1);
    run_op(1'b0, 0, 0, 1'b0, 14);
    run_op(1'b0, 0, 0, 1'b0, -1);
    run_op(1'b0, 50, 0, 1'b0, -1);
    run_op(1'b1, 50, 2, 1'b0, -1);
    for (int j = 0; j < 4; j++) begin
      run_op(1'($urandom), 0, 3, 1'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The module SHALL have parameter NR, default 10, the number of cipher rounds (AES-128).
REQ-002 The module SHALL have parameter KIDX_W, default 4, the width of the round-key index.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port start  input  1  begins one block operation when sampled high in IDLE.
REQ-006 The module SHALL have port decrypt  input  1  mode, sampled with start: 0 = encrypt, 1 = decrypt.
REQ-007 The module SHALL have port step_done  input  1  completion pulse from the currently enabled datapath step.
REQ-008 The module SHALL have port step_en  output  4  one-hot step enable {ark, mc, sr, sb}.
REQ-009 The module SHALL have port inv  output  1  inverse-step select to the SubBytes, ShiftRows and MixColumns stages.
REQ-010 The module SHALL have port key_idx  output  KIDX_W  round-key index presented to the key store.
REQ-011 The module SHALL have port busy  output  1  high from accepted start until done.
REQ-012 The module SHALL have port done  output  1  one-cycle pulse when the block operation completes.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT, FINISH.
REQ-014 In IDLE with start=1, the FSM SHALL latch decrypt, set busy, load the step sequence pointer, and go to ISSUE.
REQ-015 In ISSUE, the FSM SHALL drive exactly one step_en bit high for exactly one cycle, then go to WAIT.
REQ-016 In WAIT, step_en SHALL be 0; on step_done=1 the FSM SHALL advance to the next step (ISSUE), or go to FINISH after the last step.
REQ-017 In FINISH, the FSM SHALL pulse done for one cycle, clear busy, and return to IDLE; start-to-done latency is 2 cycles per step plus 2.
REQ-018 The encrypt sequence SHALL be: ARK(k0); for r=1..NR-1: SB, SR, MC, ARK(kr); then SB, SR, ARK(kNR), for 4*NR steps total.
REQ-019 The decrypt sequence SHALL be: ARK(kNR); for r=NR-1..1: SR, SB, ARK(kr), MC; then SR, SB, ARK(k0), for 4*NR steps total.
REQ-020 key_idx SHALL hold the index of the current round for the whole ISSUE/WAIT span of its steps; key_idx SHALL be 0 in IDLE.
REQ-021 inv SHALL equal the latched decrypt while busy, and 0 in IDLE.
REQ-022 start SHALL be ignored while busy; decrypt changes while busy SHALL have no effect.
REQ-023 A step_done received in ISSUE, IDLE or FINISH SHALL be ignored; the FSM SHALL not advance on it.
REQ-024 The FSM SHALL wait indefinitely in WAIT until step_done arrives; no timeout applies.
REQ-025 The round counter SHALL be sized to hold 0..NR with no wrap-around; the last-step detection SHALL use the full step count.

Reset
REQ-026 When rst=0, the FSM SHALL go to IDLE asynchronously, with step_en=0, inv=0, key_idx=0, busy=0, and done=0.
REQ-027 A reset during ISSUE or WAIT SHALL abandon the operation without issuing a done pulse; the FSM SHALL accept start again on the first clock edge after rst returns to 1.

Configuration
REQ-028 With macro AES_CTRL_DECRYPT_EN defined, the decrypt sequence (REQ-019) and the inv output behaviour (REQ-021) SHALL be compiled in.
REQ-029 Without AES_CTRL_DECRYPT_EN, the decrypt input SHALL be ignored, inv SHALL be tied to 0, and every start SHALL run the encrypt sequence.

Verification
REQ-030 Scenario: encrypt with NR=10 and step_done returned 1 cycle after each enable -> 40 one-hot enables in the order of REQ-018, key_idx 0..10, done pulse 82 cycles after start.
REQ-031 Scenario: decrypt with AES_CTRL_DECRYPT_EN defined -> first enable is ark with key_idx=10, last is ark with key_idx=0, inv=1 throughout busy.
REQ-032 Scenario: start pulsed at step 5 of a running operation, plus a spurious step_done in ISSUE -> no restart, step sequence unchanged, single done.
REQ-033 Scenario: rst=0 asserted mid-WAIT at round 4 -> all outputs 0 immediately, no done; a new start after release runs a full 40-step sequence.
REQ-034 Scenario: step_done delayed by 50 cycles on the mc step -> FSM holds in WAIT, step_en=0, key_idx stable, then resumes.
REQ-035 Scenario: build without AES_CTRL_DECRYPT_EN and start with decrypt=1 -> encrypt sequence runs and inv=0.
